// File: rtl/sha_result_check.sv
// Compares finished SHA hashes against a loaded 256-bit target and queues golden nonces in a FIFO.
// Optional checked-hash counter (hash_cnt) is built when SHA_CHECK_HASHCNT_EN is defined.
module sha_result_check #(
   parameter int FIFO_DEPTH = 4,
   parameter int WORD_S     = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic [WORD_S-1:0]             nonce,
   input  logic [255:0]                  H,
   input  logic [255:0]                  target,
   input  logic                          target_we,
   output logic                          found_valid,
   input  logic                          found_ready,
   output logic [WORD_S-1:0]             found_nonce,
   output logic [255:0]                  found_hash,
   output logic                          overflow,
   input  logic                          clr,
   output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef SHA_CHECK_HASHCNT_EN
   ,
   output logic [63:0]                   hash_cnt
`endif
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int NW = 256 / WORD_S;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [255:0]        target_q;
   logic                s1_valid_q;
   logic [NW-1:0]       s1_lt_q, s1_eq_q, lt_d, eq_d;
   logic [WORD_S-1:0]   s1_nonce_q;
   logic [255:0]        s1_hash_q;
   logic                s2_golden_q, golden_d;
   logic [WORD_S-1:0]   s2_nonce_q;
   logic [255:0]        s2_hash_q;

   logic [WORD_S-1:0]   nonce_mem_q [FIFO_DEPTH];
   logic [255:0]        hash_mem_q  [FIFO_DEPTH];
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                pop_d, push_d, drop_d, full_d;

   // Stage 1: independent per-word less-than / equal flags.
   always_comb begin
      lt_d = '0;
      eq_d = '0;
      for (int w = 0; w < NW; w++) begin
         lt_d[w] = H[w*WORD_S +: WORD_S] <  target_q[w*WORD_S +: WORD_S];
         eq_d[w] = H[w*WORD_S +: WORD_S] == target_q[w*WORD_S +: WORD_S];
      end
   end

   // Stage 2: a word decides the compare only if every more-significant word is equal.
   always_comb begin
      logic higher_eq;
      golden_d  = 1'b0;
      higher_eq = 1'b1;
      for (int w = NW - 1; w >= 0; w--) begin
         golden_d  = golden_d | (s1_lt_q[w] & higher_eq);
         higher_eq = higher_eq & s1_eq_q[w];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         target_q    <= 256'd0;
         s1_valid_q  <= 1'b0;
         s1_lt_q     <= '0;
         s1_eq_q     <= '0;
         s1_nonce_q  <= '0;
         s1_hash_q   <= 256'd0;
         s2_golden_q <= 1'b0;
         s2_nonce_q  <= '0;
         s2_hash_q   <= 256'd0;
      end else begin
         if (target_we) begin
            target_q <= target;
         end
         s1_valid_q  <= en;
         s1_lt_q     <= lt_d;
         s1_eq_q     <= eq_d;
         s1_nonce_q  <= nonce;
         s1_hash_q   <= H;
         s2_golden_q <= s1_valid_q & golden_d;
         s2_nonce_q  <= s1_nonce_q;
         s2_hash_q   <= s1_hash_q;
      end
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      pop_d      = (count_q != {CW{1'b0}}) && found_ready;
      full_d     = (count_q == FULL_CNT);
      push_d     = s2_golden_q && (!full_d || pop_d);
      drop_d     = s2_golden_q && full_d && !pop_d;
      rd_ptr_d   = pop_d  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d   = push_d ? wr_ptr_q + PW'(1) : wr_ptr_q;
      case ({push_d, pop_d})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (drop_d) begin
         overflow_d = 1'b1;
      end else if (clr) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            nonce_mem_q[i] <= '0;
            hash_mem_q[i]  <= 256'd0;
         end
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         if (push_d) begin
            nonce_mem_q[wr_ptr_q] <= s2_nonce_q;
            hash_mem_q[wr_ptr_q]  <= s2_hash_q;
         end
      end
   end

   assign found_valid = (count_q != {CW{1'b0}});
   assign found_nonce = nonce_mem_q[rd_ptr_q];
   assign found_hash  = hash_mem_q[rd_ptr_q];
   assign overflow    = overflow_q;
   assign count       = count_q;

`ifdef SHA_CHECK_HASHCNT_EN
   logic        s2_valid_q;
   logic [63:0] hash_cnt_q, hash_cnt_d;

   // Clear has priority over a coincident increment.
   always_comb begin
      if (clr) begin
         hash_cnt_d = 64'd0;
      end else if (s2_valid_q) begin
         hash_cnt_d = hash_cnt_q + 64'd1;
      end else begin
         hash_cnt_d = hash_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid_q <= 1'b0;
         hash_cnt_q <= 64'd0;
      end else begin
         s2_valid_q <= s1_valid_q;
         hash_cnt_q <= hash_cnt_d;
      end
   end

   assign hash_cnt = hash_cnt_q;
`endif

endmodule

// File: tb/tb_sha_result_check.sv
// Scoreboard bench for sha_result_check: expected golden results are queued when hashes are driven
// and compared as the FIFO head is consumed.
module tb_sha_result_check;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic [31:0]   nonce;
   logic [255:0]  H;
   logic [255:0]  target;
   logic          target_we;
   logic          found_valid;
   logic          found_ready;
   logic [31:0]   found_nonce;
   logic [255:0]  found_hash;
   logic          overflow;
   logic          clr;
   logic [2:0]    count;
`ifdef SHA_CHECK_HASHCNT_EN
   logic [63:0]   hash_cnt;
`endif

   int total = 0;
   int bad   = 0;
   logic [255:0] mdl_target;
   logic [31:0]  exp_n_q[$];
   logic [255:0] exp_h_q[$];

   localparam logic [255:0] T_ONE_TOP = {32'h0000_0001, 224'h0};
   localparam logic [255:0] T_MAX     = {256{1'b1}};

   sha_result_check #(.FIFO_DEPTH(4), .WORD_S(32)) dut (
      .clk(clk), .reset(reset), .en(en), .nonce(nonce), .H(H),
      .target(target), .target_we(target_we),
      .found_valid(found_valid), .found_ready(found_ready),
      .found_nonce(found_nonce), .found_hash(found_hash),
      .overflow(overflow), .clr(clr), .count(count)
`ifdef SHA_CHECK_HASHCNT_EN
      , .hash_cnt(hash_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_hash(input logic [255:0] h, input logic [31:0] n, input bit keep);
      en    = 1'b1;
      H     = h;
      nonce = n;
      if (keep && (h < mdl_target)) begin
         exp_n_q.push_back(n);
         exp_h_q.push_back(h);
      end
   endtask

   task automatic load_target(input logic [255:0] t);
      target     = t;
      target_we  = 1'b1;
      mdl_target = t;
      tick();
      target_we  = 1'b0;
   endtask

   task automatic sb_pop(output logic [31:0] n, output logic [255:0] h, output bit ok);
      ok = (exp_n_q.size() != 0);
      n  = 32'd0;
      h  = 256'd0;
      if (ok) begin
         n = exp_n_q.pop_front();
         h = exp_h_q.pop_front();
      end
   endtask

   task automatic test_reset();
      total++; if (found_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", found_valid); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      total++; if (found_nonce !== 32'd0) begin bad++; $display("FAIL reset_nonce: got %h want 0", found_nonce); end
      total++; if (found_hash !== 256'd0) begin bad++; $display("FAIL reset_hash: got %h want 0", found_hash); end
   endtask

   task automatic test_equal_zero();
      drive_hash(256'd0, 32'd5, 1'b1);
      tick();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (found_valid !== 1'b0) begin bad++; $display("FAIL eq_zero_valid cyc%0d: got %b want 0", i, found_valid); end
      end
   endtask

   task automatic test_latency();
      logic [31:0] n; logic [255:0] h; bit ok;
      load_target(T_ONE_TOP);
      drive_hash({32'h0, {224{1'b1}}}, 32'hDEAD_BEEF, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         en = 1'b0;
         total++; if (found_valid !== (i == 3)) begin bad++; $display("FAIL latency_valid clk%0d: got %b want %b", i, found_valid, (i == 3)); end
      end
      sb_pop(n, h, ok);
      total++; if (!ok || found_nonce !== n) begin bad++; $display("FAIL latency_nonce: got %h want %h", found_nonce, n); end
      total++; if (!ok || found_hash !== h) begin bad++; $display("FAIL latency_hash: got %h want %h", found_hash, h); end
      found_ready = 1'b1;
      tick();
      found_ready = 1'b0;
      total++; if (found_valid !== 1'b0) begin bad++; $display("FAIL latency_pop: got %b want 0", found_valid); end
      drive_hash(T_ONE_TOP, 32'h0000_1234, 1'b1);
      tick();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (found_valid !== 1'b0) begin bad++; $display("FAIL equal_target cyc%0d: got %b want 0", i, found_valid); end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] n; logic [255:0] h; bit ok;
      load_target(T_MAX);
      found_ready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         drive_hash({8{32'(i)}}, 32'(i), (i <= 4));
         tick();
      end
      en = 1'b0;
      repeat (4) tick();
      total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", count); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      total++; if (found_nonce !== 32'd1) begin bad++; $display("FAIL ovf_head: got %h want 1", found_nonce); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", overflow); end
      total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_clr_count: got %0d want 4", count); end
      found_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (found_valid === 1'b1) begin
            sb_pop(n, h, ok);
            total++; if (!ok || found_nonce !== n || found_hash !== h) begin bad++; $display("FAIL ovf_drain: got %h want %h", found_nonce, n); end
         end
         tick();
      end
      found_ready = 1'b0;
      total++; if (found_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", found_valid); end
      total++; if (exp_n_q.size() != 0) begin bad++; $display("FAIL ovf_sb_left: got %0d want 0", exp_n_q.size()); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] n; logic [255:0] h; bit ok;
      bit rdy_on = 1'b0;
      found_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bit was_on;
         was_on = rdy_on;
         drive_hash({8{32'(100 + i)}}, 32'(100 + i), 1'b1);
         tick();
         if (was_on) begin
            total++; if (count !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL b2b_full cyc%0d: got count=%0d ovf=%b want 4/0", i, count, overflow); end
         end
         if (!rdy_on && count === 3'd4) begin
            rdy_on      = 1'b1;
            found_ready = 1'b1;
         end
         if (rdy_on && found_valid === 1'b1) begin
            sb_pop(n, h, ok);
            total++; if (!ok || found_nonce !== n || found_hash !== h) begin bad++; $display("FAIL b2b_order: got %h want %h", found_nonce, n); end
         end
      end
      en = 1'b0;
      found_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (found_valid === 1'b1) begin
            sb_pop(n, h, ok);
            total++; if (!ok || found_nonce !== n || found_hash !== h) begin bad++; $display("FAIL b2b_drain: got %h want %h", found_nonce, n); end
         end
      end
      found_ready = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
      total++; if (exp_n_q.size() != 0) begin bad++; $display("FAIL b2b_sb_left: got %0d want 0", exp_n_q.size()); end
   endtask

   task automatic test_reset_midstream();
      found_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_hash({8{32'(200 + i)}}, 32'(200 + i), 1'b1);
         tick();
      end
      en = 1'b0;
      total++; if (count !== 3'd2) begin bad++; $display("FAIL midrst_pre_count: got %0d want 2", count); end
      #2 reset = 1'b0;
      #1;
      total++; if (found_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", found_valid); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", count); end
      exp_n_q.delete();
      exp_h_q.delete();
      mdl_target = 256'd0;
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++; if (found_valid !== 1'b0) begin bad++; $display("FAIL midrst_after cyc%0d: got %b want 0", i, found_valid); end
      end
   endtask

`ifdef SHA_CHECK_HASHCNT_EN
   task automatic test_hash_cnt();
      logic [31:0] n; logic [255:0] h; bit ok;
      load_target(T_ONE_TOP);
      for (int i = 0; i < 10; i++) begin
         if (i == 2 || i == 5 || i == 8) drive_hash({32'h0, {7{32'(i)}}}, 32'(300 + i), 1'b1);
         else                            drive_hash({32'h2, {7{32'(i)}}}, 32'(300 + i), 1'b1);
         tick();
      end
      en = 1'b0;
      repeat (4) tick();
      total++; if (hash_cnt !== 64'd10) begin bad++; $display("FAIL hashcnt_val: got %0d want 10", hash_cnt); end
      total++; if (count !== 3'd3) begin bad++; $display("FAIL hashcnt_golden: got %0d want 3", count); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      total++; if (hash_cnt !== 64'd0) begin bad++; $display("FAIL hashcnt_clr: got %0d want 0", hash_cnt); end
      found_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (found_valid === 1'b1) begin
            sb_pop(n, h, ok);
            total++; if (!ok || found_nonce !== n || found_hash !== h) begin bad++; $display("FAIL hashcnt_drain: got %h want %h", found_nonce, n); end
         end
         tick();
      end
      found_ready = 1'b0;
      total++; if (exp_n_q.size() != 0) begin bad++; $display("FAIL hashcnt_sb_left: got %0d want 0", exp_n_q.size()); end
   endtask
`endif

   initial begin
      reset       = 1'b0;
      en          = 1'b0;
      nonce       = 32'd0;
      H           = 256'd0;
      target      = 256'd0;
      target_we   = 1'b0;
      found_ready = 1'b0;
      clr         = 1'b0;
      mdl_target  = 256'd0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      test_reset();
      test_equal_zero();
      test_latency();
      test_overflow();
      test_back_to_back();
      test_reset_midstream();
`ifdef SHA_CHECK_HASHCNT_EN
      test_hash_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha_result_check.md
Name: sha_result_check

Overview:
- Downstream consumer of the SHA pipeline block.
- Takes each finished hash (H, nonce_out, en_next) and compares it against a loaded 256-bit difficulty target.
- Nonces whose hash is strictly below the target are buffered in a small FIFO and handed to the host/controller side over a valid/ready handshake.
- Keeps sticky overflow status and a checked-hash counter.

Parameters:
- FIFO_DEPTH, 4, entries in the golden-nonce FIFO; power of two, 2..16.
- WORD_S, 32, nonce/word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  hash-valid strobe; driven by the pipeline's en_next; one hash per asserted cycle, may be asserted every cycle.
- nonce  in  WORD_S  nonce belonging to H.
- H  in  256  finished hash; H[255:224] is the most significant word.
- target  in  256  new target value.
- target_we  in  1  load target on this cycle.
- found_valid  out  1  FIFO head holds a golden result.
- found_ready  in  1  consumer accepts head.
- found_nonce  out  WORD_S  nonce at FIFO head.
- found_hash  out  256  hash at FIFO head.
- overflow  out  1  sticky: a golden result was dropped.
- clr  in  1  synchronous clear of overflow (and counter when enabled).
- count  out  FIFO_DEPTH-width+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous): target register=0, so nothing matches; FIFO empty; found_valid=0, found_nonce=0, found_hash=0, overflow=0, count=0; pipeline valids cleared. Any in-flight hash is discarded.
- Target: on target_we=1 the target register loads at the clock edge.
  - Hashes whose stage-1 compare happens on or after the following edge use the new value.
  - A hash in stage 1 in the same cycle as target_we uses the old value.
- Comparison: unsigned 256-bit, golden iff H < target (equal is not golden). Two-stage pipeline:
  - S1 (edge 1 after en): per 32-bit word w=0..7, register lt[w]=(H_w<T_w) and eq[w]=(H_w==T_w), plus nonce, H and valid.
  - S2 (edge 2): golden = OR over w of (lt[w] AND eq of all more-significant words). Register golden-valid, nonce and H.
  - The FIFO write occurs at edge 3. found_valid therefore rises 3 clocks after en, when the FIFO was empty.
  - Full throughput: one hash per cycle, no backpressure toward the pipeline. The pipeline cannot stall, so en is never refused.
- FIFO:
  - Circular buffer with read/write pointers plus a count register; pointers wrap modulo FIFO_DEPTH.
  - Head is registered output; first-word fall-through: found_valid=(count!=0), and found_nonce/found_hash show the head entry.
  - Pop on found_valid&&found_ready.
  - Write when S2 golden-valid and (count<FIFO_DEPTH, or a pop happens the same cycle).
  - Simultaneous push and pop when full: both occur, count unchanged, no overflow.
  - Push when full with no pop: entry dropped, overflow<=1, FIFO contents unchanged.
  - Simultaneous push and pop when empty: no hazard, since found_valid=0; push proceeds.
  - found_ready while empty: ignored.
- Output stability: found_nonce/found_hash are held while found_valid=1 and found_ready=0.
- clr: overflow<=0 next edge. If an overflow event coincides with clr, overflow stays 1; set wins.
- Non-golden hashes affect nothing except the optional counter.

Optional Feature:
- Macro SHA_CHECK_HASHCNT_EN.
- Defined:
  - Adds output hash_cnt [63:0].
  - Increments once per S2 valid, golden or not; reset 0.
  - clr zeroes it; when clr and an increment coincide, the result is 0.
  - Wraps from 2^64-1 to 0.
- Undefined: no port, no counter logic.

Test Plan:
- Reset then en=1 with H=0, nonce=5, target=0 -> no found_valid; equality with 0 is never golden.
- target_we with target=256'h0000_0001_0...0, then H=256'h0000_0000_FFFF...F, nonce=32'hDEADBEEF -> found_valid=1 exactly 3 clocks after en, found_nonce=DEADBEEF; H=target exactly -> not captured.
- 8 consecutive golden hashes, nonces 1..8, FIFO_DEPTH=4, found_ready=0 -> count=4, nonces 1..4 held, overflow=1; clr -> overflow=0; drain pops in order 1,2,3,4, then found_valid=0.
- FIFO full with found_ready=1 every cycle and continuous golden en -> no overflow, count stays 4, output order strictly increasing.
- Assert reset low mid-stream with 2 entries queued and 2 hashes in flight -> found_valid=0 and count=0 immediately, asynchronously; nothing is emitted after release.
- With SHA_CHECK_HASHCNT_EN: 10 hashes, 3 golden -> hash_cnt=10; clr -> 0.
